// File: rtl/alu_pkg.sv
// Shared ALU definitions: result width, all-ones compare value and the
// {data, zero} result record carried through the result buffer.
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam logic [ALU_WIDTH-1:0] ALU_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 zero;
  } alu_result_t;
endpackage

// File: rtl/alu_rb_mem.sv
// Entry storage for alu_result_buffer: one write port, one asynchronous
// read port, no reset (entries are only reachable through the pointers).
module alu_rb_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW-1:0] waddr,
  input  alu_result_t wdata,
  input  logic [AW-1:0] raddr,
  output alu_result_t rdata
);
  alu_result_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_buffer.sv
// In-order result FIFO between the ALU and writeback, with synchronous flush.
// Define ALU_RB_STATS_EN to add the saturating zero-result counter.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [WIDTH-1:0]       res_data,
  input  logic                   res_zero,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [WIDTH-1:0]       wb_data,
  output logic                   wb_zero,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef ALU_RB_STATS_EN
  ,
  output logic [CNT_W-1:0]       zero_cnt,
  input  logic                   stats_clr
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop, we;
  alu_result_t wr_ent, rd_ent;

  // Extra MSB is the wrap bit: equal -> empty, differ only in MSB -> full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign res_ready = !full;
  assign wb_valid  = !empty;
  assign push      = res_valid && !full;
  assign pop       = !empty && wb_ready;
  assign we        = push && !flush;
  assign occupancy = wptr - rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign wr_ent.data = ALU_WIDTH'(res_data);
  assign wr_ent.zero = res_zero;

  alu_rb_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_ent),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_ent)
  );

  // Head is masked when empty so stale storage never leaks out.
  assign wb_data = empty ? '0 : WIDTH'(rd_ent.data);
  assign wb_zero = empty ? 1'b0 : rd_ent.zero;

`ifdef ALU_RB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  zero_cnt <= '0;
    else if (stats_clr)                          zero_cnt <= '0;
    else if (we && res_zero && zero_cnt != '1)   zero_cnt <= zero_cnt + 1'b1;
  end
`endif
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered result stage directly downstream of the ALU compare/arithmetic units. It accepts each 32-bit ALU result together with its zero flag over a valid/ready handshake and holds it in a small FIFO. It presents the results in order to the writeback stage, so ALU output is decoupled from writeback stalls. It also provides a synchronous flush for pipeline squash.

## Interface
Parameters:
- WIDTH, 32, result data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of zero-result statistics counter (used only with ALU_RB_STATS_EN)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all entries
- res_valid  input  1  ALU result valid
- res_ready  output  1  buffer can accept (= not full)
- res_data  input  WIDTH  ALU result (e.g. all-ones/zero compare output)
- res_zero  input  1  ALU zero flag for res_data
- wb_valid  output  1  head entry valid
- wb_ready  input  1  writeback consumes head
- wb_data  output  WIDTH  head result
- wb_zero  output  1  head zero flag
- occupancy  output  $clog2(DEPTH)+1  entries held
- zero_cnt  output  CNT_W  accepted results with res_zero=1 (ALU_RB_STATS_EN only)
- stats_clr  input  1  clear zero_cnt (ALU_RB_STATS_EN only)

## Operation
- Push occurs when res_valid && res_ready. Pop occurs when wb_valid && wb_ready.
- Storage: DEPTH entries of {data, zero}. Write pointer and read pointer are each $clog2(DEPTH)+1 bits, with the extra bit used as a wrap bit.
- Full: the pointers differ only in the MSB. Empty: the pointers are equal.
- res_ready = !full. It is driven from registered pointers and never depends combinationally on wb_ready.
- Push and pop in the same cycle:
  - When neither full nor empty, both happen and occupancy is unchanged.
  - When full, only the pop happens, because res_ready=0.
  - When empty, only the push happens; there is no fall-through.
- Outputs: wb_valid = !empty. wb_data and wb_zero come from the head entry, and are 0 when empty.
- The buffer does not recompute the flag. wb_zero is exactly the res_zero that was captured with the entry.
- flush=1:
  - Next cycle, both pointers are 0, occupancy is 0 and wb_valid is 0.
  - Flush overrides any push or pop in the same cycle; the incoming result is dropped.
  - zero_cnt is unaffected.
- Pointers wrap modulo 2·DEPTH. Data order is preserved across wrap.
- Holding rule: while wb_valid=1 && wb_ready=0, wb_data and wb_zero stay stable.

## Timing
- Reset (rst_n=0, async assert): pointers=0, occupancy=0, res_ready=1, wb_valid=0, wb_data=0, wb_zero=0, zero_cnt=0. Deassertion takes effect at the next clk edge.
- Latency: a result pushed at edge N is visible on wb_* after edge N, when the buffer was empty before that push.
- Throughput: one push and one pop per cycle in steady state.
- Reset mid-operation discards all entries immediately. Storage contents are not cleared, but are unreachable because the pointers are reset.

## Configuration
- ALU_RB_STATS_EN:
  - Defined: adds ports zero_cnt and stats_clr. zero_cnt increments on every push with res_zero=1 and saturates at 2^CNT_W−1. stats_clr=1 sets it to 0 next cycle and takes priority over an increment in the same cycle.
  - Undefined: neither port exists, no counter logic is built, and the remaining behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - ALU_WIDTH=32
  - ALU_ONES = 32'hFFFF_FFFF
  - typedef alu_result_t {logic [ALU_WIDTH-1:0] data; logic zero;}
- The entry array is one sub-module, alu_rb_mem: DEPTH×alu_result_t, one write port, one asynchronous read port, no reset.
- Pointer, flag and statistics logic live in alu_result_buffer.

## Test plan
- Reset, then push 32'hFFFF_FFFF/zero=0 → wb_valid=1 one cycle later, wb_data=FFFF_FFFF, wb_zero=0, occupancy=1.
- Push 4 entries with wb_ready=0 → res_ready=0 after the 4th. A 5th res_valid is ignored. Drain returns all 4 in order.
- Push and pop every cycle for 10 results (0..9) with DEPTH=4 → pointers wrap, outputs are 0..9 in order, occupancy stays 1.
- Fill with 3 entries, assert flush together with res_valid → next cycle occupancy=0 and wb_valid=0; the flushed-cycle result never appears.
- ALU_RB_STATS_EN, CNT_W=2: push 5 results with zero=1 → zero_cnt saturates at 3. Pulse stats_clr while pushing a zero=1 result → zero_cnt=0.
- Assert rst_n=0 mid-burst with 2 entries queued → wb_valid=0 and res_ready=1 immediately, without waiting for a clk edge.
